playback_sequencer: RTL and testbench
=====================================

# playback_sequencer

Sequences playback of one stored audio segment for the speech synthesizer. It fetches 8-bit samples from a word-addressed sample memory through a req/ack handshake and paces their output with a programmable sample-period divider. The divider value comes from the speed-control block, so playback rate follows the up/down/normal speed selection. The block sits between the speed control, the sample memory interface and the audio output path.

## Interface
- ADDR_W, 23, sample memory address width
- MIN_DIV, 2, smallest accepted divider (clock cycles per sample)
- MAX_DIV, 65535, largest accepted divider
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to play segment [start_addr..end_addr]
- stop  in  1  one-cycle abort request
- start_addr  in  ADDR_W  first sample address; sampled when start is accepted
- end_addr  in  ADDR_W  last sample address, inclusive; sampled when start is accepted
- div_val  in  32  clock cycles per sample, from speed control
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  read address; stable while mem_req is high
- mem_ack  in  1  read complete; mem_data valid in the same cycle
- mem_data  in  8  read sample
- sample_out  out  8  current output sample; holds its value between updates
- sample_valid  out  1  one-cycle pulse when sample_out updates
- busy  out  1  segment in progress
- done  out  1  one-cycle pulse with the final sample_valid, or on stop completion
- underrun  out  1  sticky flag: a sample tick arrived before its data; cleared by accepted start

## Operation
- Reset values: all outputs 0, state IDLE, counter 0, buffer empty.
- States:
  - IDLE: on start, latch the addresses, set cur_addr=start_addr, load D from div_val, clear counter and underrun, then go to FETCH. start is ignored in any other state.
  - FETCH: mem_req=1, mem_addr=cur_addr. On mem_ack, capture mem_data into the buffer, drop mem_req, go to WAIT.
  - WAIT: hold until tick. On tick, sample_out<=buffer and pulse sample_valid. If cur_addr==end_addr, go to DONE; else increment cur_addr and go to FETCH.
  - DONE: pulse done, go to IDLE.
- Tick counter:
  - Runs from start acceptance until DONE, independent of FETCH/WAIT.
  - Tick occurs when counter==D-1. At the tick, counter clears and D reloads from div_val.
  - Clamping: div_val<MIN_DIV gives D=MIN_DIV; div_val>MAX_DIV gives D=MAX_DIV. Wrapped or huge speed values therefore saturate.
  - Counter and D are each 16 bits wide internally.
- Underrun: if a tick occurs while in FETCH, set underrun and a tick_pending flag. When mem_ack arrives, output that data directly (sample_valid in the cycle after ack), then continue as if the tick had occurred in WAIT. The counter keeps running during this; lost ticks are not accumulated.
- end_addr<start_addr: only start_addr is played; this is treated as a single-sample segment.
- stop:
  - In WAIT: go to DONE next cycle. No further samples are output.
  - In FETCH: mem_req stays high until mem_ack, the data is discarded, then go to DONE. The handshake is never dropped mid-request.
  - stop in IDLE is ignored. start and stop in the same IDLE cycle: start wins; stop is ignored.
- busy=1 in every state except IDLE.
- Asynchronous reset mid-operation: return to IDLE immediately. mem_req drops without waiting for ack.

## Timing
- start high in cycle 0 gives mem_req=1 and busy=1 in cycle 1. Counter=0 in cycle 1.
- mem_ack in cycle n gives mem_req=0 in cycle n+1.
- First tick in cycle D (counter==D-1); sample_valid=1 in cycle D+1, provided data was captured earlier.
- Subsequent sample_valid pulses are spaced exactly D cycles apart, using the D reloaded at each tick. Requires memory latency < D-1.
- done coincides with the last sample_valid, and busy=0 the following cycle. For stop completion, done occurs in the cycle after DONE is entered, and busy=0 the cycle after that.

## Test plan
- Basic playback: D=4, mem_ack in the same cycle as mem_req, segment 0x10..0x12 with data A0,A1,A2, start in cycle 0 -> sample_valid in cycles 5, 9, 13 with A0, A1, A2; done in cycle 13; busy=0 in cycle 14; underrun=0.
- Rate change: div_val changes from 8 to 4 after the first tick -> spacing between the first two samples is 8 and subsequent spacing is 4.
- Clamping: div_val=0 -> samples spaced 2 cycles apart; div_val=0xFFFF_F000 -> spacing 65535.
- Underrun: D=4, mem_ack delayed 6 cycles -> underrun=1, and sample_valid in the cycle after the late ack; underrun clears on the next start.
- Stop in FETCH with ack delayed 3 cycles -> mem_req held until ack, no sample output, done pulse, then idle; start while busy is ignored (addresses unchanged).
- Single-sample segment: end_addr<start_addr -> exactly one sample_valid, with done at the same time. Async reset asserted mid-FETCH -> mem_req=0 and busy=0 immediately.

Source files
------------

// File: rtl/playback_sequencer_if.sv
// Sample-memory read port: req/ack handshake carrying a word address out and one 8-bit sample back.
interface playback_sequencer_if #(
    parameter int unsigned ADDR_W = 23
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [7:0]        mem_data;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_data);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/playback_sequencer.sv
// Plays one stored segment: fetches samples over the memory handshake and releases
// them at a programmable sample period taken from the speed control.
module playback_sequencer #(
    parameter int unsigned ADDR_W  = 23,
    parameter int unsigned MIN_DIV = 2,
    parameter int unsigned MAX_DIV = 65535
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic [ADDR_W-1:0]    start_addr,
    input  logic [ADDR_W-1:0]    end_addr,
    input  logic [31:0]          div_val,
    playback_sequencer_if.master mem,
    output logic [7:0]           sample_out,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 underrun
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WAIT, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d, end_q, end_d;
    logic              single_q, single_d;
    logic [CNT_W-1:0]  div_q, div_d, cnt_q, cnt_d;
    logic [7:0]        buf_q, buf_d, out_d;
    logic              pend_q, pend_d, abort_q, abort_d, req_q, req_d;
    logic              valid_d, busy_d, done_d, under_d;
    logic              running, tick, ack, last, aborting;

    function automatic logic [CNT_W-1:0] clamp_div(input logic [31:0] v);
        if (v < 32'(MIN_DIV)) return CNT_W'(MIN_DIV);
        if (v > 32'(MAX_DIV)) return CNT_W'(MAX_DIV);
        return v[CNT_W-1:0];
    endfunction

    assign running  = (state_q == ST_FETCH) || (state_q == ST_WAIT);
    assign tick     = running && (cnt_q == div_q - CNT_W'(1));
    assign ack      = (state_q == ST_FETCH) && req_q && mem.mem_ack;
    assign last     = single_q || (cur_q == end_q);
    assign aborting = abort_q || stop;

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = cur_q;

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        end_d    = end_q;
        single_d = single_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        pend_d   = pend_q;
        abort_d  = abort_q;
        out_d    = sample_out;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        under_d  = underrun;

        if (tick) begin
            cnt_d = '0;
            div_d = clamp_div(div_val);
        end else if (running) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_FETCH;
                    cur_d    = start_addr;
                    end_d    = end_addr;
                    single_d = (end_addr < start_addr);
                    div_d    = clamp_div(div_val);
                    cnt_d    = '0;
                    under_d  = 1'b0;
                    pend_d   = 1'b0;
                    abort_d  = 1'b0;
                end
            end
            ST_FETCH: begin
                if (stop) abort_d = 1'b1;
                if (tick && !ack && !aborting) begin
                    under_d = 1'b1;
                    pend_d  = 1'b1;
                end
                if (ack) begin
                    pend_d = 1'b0;
                    if (aborting) begin
                        state_d = ST_DONE;
                    end else if (pend_q || tick) begin
                        // Late data goes straight out; the request drops for one cycle before the next fetch
                        out_d   = mem.mem_data;
                        valid_d = 1'b1;
                        if (last) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            cur_d = cur_q + ADDR_W'(1);
                        end
                    end else begin
                        buf_d   = mem.mem_data;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (stop) begin
                    state_d = ST_DONE;
                    abort_d = 1'b1;
                end else if (tick) begin
                    out_d   = buf_q;
                    valid_d = 1'b1;
                    if (last) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        cur_d   = cur_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                // An aborted segment spends one extra cycle here to emit its done pulse
                if (abort_q) begin
                    done_d  = 1'b1;
                    abort_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_d  = (state_d == ST_FETCH) && !ack;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cur_q        <= '0;
            end_q        <= '0;
            single_q     <= 1'b0;
            div_q        <= '0;
            cnt_q        <= '0;
            buf_q        <= '0;
            pend_q       <= 1'b0;
            abort_q      <= 1'b0;
            req_q        <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            end_q        <= end_d;
            single_q     <= single_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            pend_q       <= pend_d;
            abort_q      <= abort_d;
            req_q        <= req_d;
            sample_out   <= out_d;
            sample_valid <= valid_d;
            busy         <= busy_d;
            done         <= done_d;
            underrun     <= under_d;
        end
    end
endmodule

// File: tb/tb_playback_sequencer.sv
// Self-checking bench for playback_sequencer: schedule model for whole segments plus
// directed checks for stop, clamping, and reset.
module tb_playback_sequencer;
    localparam int unsigned ADDR_W = 23;
    localparam int N = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start, stop;
    logic [ADDR_W-1:0] start_addr, end_addr;
    logic [31:0]       div_val;
    logic [7:0]        sample_out;
    logic              sample_valid, busy, done, underrun;

    playback_sequencer_if #(.ADDR_W(ADDR_W)) mif ();

    playback_sequencer #(.ADDR_W(ADDR_W), .MIN_DIV(2), .MAX_DIV(65535)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .start_addr(start_addr), .end_addr(end_addr), .div_val(div_val),
        .mem(mif.master), .sample_out(sample_out), .sample_valid(sample_valid),
        .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0, t0 = 0, lat = 0, age = 0, vcount = 0;
    bit model_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc - t0, act, exp);
        end
    endtask

    task automatic wait_neg(input int k);
        do @(negedge clk); while (cyc - t0 < k);
    endtask

    // Memory: acks lat cycles after the request rises; data = address + 0x90
    initial begin
        mif.mem_ack  = 1'b0;
        mif.mem_data = 8'h00;
        forever begin
            @(negedge clk);
            if (mif.mem_req === 1'b1) begin
                mif.mem_ack  = (age == lat);
                mif.mem_data = 8'(mif.mem_addr + ADDR_W'(8'h90));
                age++;
            end else begin
                mif.mem_ack = 1'b0;
                age = 0;
            end
        end
    end

    always @(negedge clk) if (sample_valid === 1'b1) vcount++;

    // Expected per-cycle behaviour relative to the start cycle
    bit                e_valid[N], e_done[N], e_busy[N], e_req[N], e_und[N];
    logic [7:0]        e_data[N], e_out[N];
    logic [ADDR_W-1:0] e_addr[N];
    logic [7:0]        last_out;

    function automatic int clampd(input int unsigned v);
        if (v < 2) return 2;
        if (v > 65535) return 65535;
        return int'(v);
    endfunction

    // Schedule model: tick times are running sums of clamped periods; each sample goes out
    // one cycle after its tick, or one cycle after its ack if the ack came at/after the tick.
    task automatic build_model(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                               input int l, input int unsigned d0, input int unsigned d1, input int chg);
        int n, e, f, a, t, v, und_from;
        bit pend;
        logic [7:0] run;
        for (int k = 0; k < N; k++) begin
            e_valid[k] = 0; e_done[k] = 0; e_busy[k] = 0; e_req[k] = 0; e_und[k] = 0;
            e_data[k] = 8'h00; e_out[k] = 8'h00; e_addr[k] = '0;
        end
        n = (ea < sa) ? 1 : int'(ea - sa) + 1;
        t = clampd(d0);
        e = 1; pend = 0; und_from = N; v = 0;
        for (int i = 0; i < n; i++) begin
            f = pend ? e + 1 : e;
            a = f + l;
            for (int c = f; c <= a && c < N; c++) begin
                e_req[c]  = 1;
                e_addr[c] = sa + ADDR_W'(i);
            end
            while (t < e) t += clampd((t >= chg) ? d1 : d0);
            if (t > a) begin
                v = t + 1; pend = 0;
            end else begin
                if (t < a && t + 1 < und_from) und_from = t + 1;
                v = a + 1; pend = 1;
            end
            if (v < N) begin
                e_valid[v] = 1;
                e_data[v]  = 8'(sa + ADDR_W'(i) + ADDR_W'(8'h90));
            end
            e = v;
        end
        if (v < N) e_done[v] = 1;
        run = last_out;
        for (int k = 1; k < N; k++) begin
            e_busy[k] = (k <= v);
            e_und[k]  = (k >= und_from);
            if (e_valid[k]) run = e_data[k];
            e_out[k] = run;
        end
        last_out = run;
    endtask

    always @(negedge clk) begin : cmp
        int k;
        k = cyc - t0;
        if (model_on && k >= 1 && k < N) begin
            chk("sample_valid", 32'(sample_valid), 32'(e_valid[k]));
            chk("sample_out", 32'(sample_out), 32'(e_out[k]));
            chk("done", 32'(done), 32'(e_done[k]));
            chk("busy", 32'(busy), 32'(e_busy[k]));
            chk("mem_req", 32'(mif.mem_req), 32'(e_req[k]));
            chk("underrun", 32'(underrun), 32'(e_und[k]));
            if (e_req[k]) chk("mem_addr", 32'(mif.mem_addr), 32'(e_addr[k]));
        end
    end

    task automatic begin_seg(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                             input int l, input logic [31:0] d);
        lat = l; div_val = d; start_addr = sa; end_addr = ea;
        t0 = cyc; start = 1'b1;
        wait_neg(1);
        start = 1'b0;
    endtask

    task automatic begin_model(input logic [ADDR_W-1:0] sa, input logic [ADDR_W-1:0] ea,
                               input int l, input int unsigned d0, input int unsigned d1, input int chg);
        build_model(sa, ea, l, d0, d1, chg);
        lat = l; div_val = d0; start_addr = sa; end_addr = ea;
        t0 = cyc; start = 1'b1; model_on = 1'b1;
        wait_neg(1);
        start = 1'b0;
    endtask

    task automatic end_model();
        wait_neg(N);
        model_on = 1'b0;
    endtask

    int vsnap;

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0;
        start_addr = '0; end_addr = '0; div_val = 32'd4; last_out = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst sample_out", 32'(sample_out), 32'h0);
        chk("rst sample_valid", 32'(sample_valid), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst done", 32'(done), 32'h0);
        chk("rst underrun", 32'(underrun), 32'h0);
        chk("rst mem_req", 32'(mif.mem_req), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic playback
        begin_model(ADDR_W'('h10), ADDR_W'('h12), 0, 4, 4, 1000);
        wait_neg(5);  chk("basic v1", 32'(sample_valid), 32'h1); chk("basic d1", 32'(sample_out), 32'hA0);
        wait_neg(9);  chk("basic v2", 32'(sample_valid), 32'h1); chk("basic d2", 32'(sample_out), 32'hA1);
        wait_neg(13); chk("basic v3", 32'(sample_valid), 32'h1); chk("basic d3", 32'(sample_out), 32'hA2);
        chk("basic done", 32'(done), 32'h1);
        wait_neg(14); chk("basic idle", 32'(busy), 32'h0); chk("basic und", 32'(underrun), 32'h0);
        end_model();

        // Rate change 8 -> 4 after the first tick
        begin_model(ADDR_W'('h20), ADDR_W'('h23), 0, 8, 4, 9);
        wait_neg(9);  chk("rate v1", 32'(sample_valid), 32'h1);
        div_val = 32'd4;
        wait_neg(17); chk("rate v2", 32'(sample_valid), 32'h1);
        wait_neg(21); chk("rate v3", 32'(sample_valid), 32'h1);
        end_model();

        // Clamp low: div 0 behaves as 2
        begin_model(ADDR_W'('h30), ADDR_W'('h32), 0, 0, 0, 1000);
        wait_neg(3); chk("clamp lo v1", 32'(sample_valid), 32'h1);
        wait_neg(5); chk("clamp lo v2", 32'(sample_valid), 32'h1);
        end_model();

        // Underrun with late ack
        begin_model(ADDR_W'('h40), ADDR_W'('h41), 6, 4, 4, 1000);
        wait_neg(4); chk("und pre", 32'(underrun), 32'h0);
        wait_neg(5); chk("und set", 32'(underrun), 32'h1);
        wait_neg(8); chk("und late v", 32'(sample_valid), 32'h1); chk("und late d", 32'(sample_out), 32'hD0);
        end_model();

        // Next start clears underrun
        chk("und sticky", 32'(underrun), 32'h1);
        begin_model(ADDR_W'('h50), ADDR_W'('h51), 0, 4, 4, 1000);
        chk("und cleared", 32'(underrun), 32'h0);
        end_model();

        // end < start plays only the first sample
        begin_model(ADDR_W'('h60), ADDR_W'('h05), 1, 5, 5, 1000);
        wait_neg(6); chk("single v", 32'(sample_valid), 32'h1); chk("single d", 32'(sample_out), 32'hF0);
        chk("single done", 32'(done), 32'h1);
        wait_neg(7); chk("single idle", 32'(busy), 32'h0);
        end_model();

        // Stop in FETCH; start while busy is ignored
        vsnap = vcount;
        begin_seg(ADDR_W'('h20), ADDR_W'('h25), 3, 32'd100);
        chk("sf busy", 32'(busy), 32'h1);
        wait_neg(2); stop = 1'b1;
        wait_neg(3); stop = 1'b0; start = 1'b1; start_addr = ADDR_W'('h55); end_addr = ADDR_W'('h60);
        wait_neg(4); start = 1'b0;
        chk("sf req held", 32'(mif.mem_req), 32'h1); chk("sf addr", 32'(mif.mem_addr), 32'h20);
        wait_neg(5); chk("sf req drop", 32'(mif.mem_req), 32'h0); chk("sf done early", 32'(done), 32'h0);
        wait_neg(6); chk("sf done", 32'(done), 32'h1); chk("sf busy6", 32'(busy), 32'h1);
        wait_neg(7); chk("sf idle", 32'(busy), 32'h0); chk("sf done off", 32'(done), 32'h0);
        wait_neg(10); chk("sf no sample", 32'(vcount), 32'(vsnap));

        // start and stop together: start wins; later stop in WAIT
        vsnap = vcount;
        stop = 1'b1;
        begin_seg(ADDR_W'('h30), ADDR_W'('h35), 0, 32'd10);
        stop = 1'b0;
        chk("ss busy", 32'(busy), 32'h1);
        wait_neg(3); stop = 1'b1;
        wait_neg(4); stop = 1'b0;
        chk("sw req", 32'(mif.mem_req), 32'h0); chk("sw done early", 32'(done), 32'h0);
        wait_neg(5); chk("sw done", 32'(done), 32'h1);
        wait_neg(6); chk("sw idle", 32'(busy), 32'h0);
        wait_neg(14); chk("sw no sample", 32'(vcount), 32'(vsnap));

        // Clamp high: huge divider saturates at 65535
        begin_seg(ADDR_W'('h40), ADDR_W'('h40), 0, 32'hFFFF_F000);
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) break;
        end
        chk("clamp hi cycle", 32'(cyc - t0), 32'd65536);
        chk("clamp hi done", 32'(done), 32'h1);
        chk("clamp hi d", 32'(sample_out), 32'hD0);
        @(negedge clk);
        chk("clamp hi idle", 32'(busy), 32'h0);

        // Async reset mid-FETCH
        begin_seg(ADDR_W'('h70), ADDR_W'('h71), 20, 32'd100);
        wait_neg(3); chk("ar req", 32'(mif.mem_req), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("ar req drop", 32'(mif.mem_req), 32'h0);
        chk("ar busy drop", 32'(busy), 32'h0);
        chk("ar out", 32'(sample_out), 32'h0);
        wait_neg(4); reset_n = 1'b1;
        wait_neg(6); chk("ar stays idle", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
